// File: rtl/sd_test_pkg.sv
// Shared types and constants for the SD-card self-test sequencer.
package sd_test_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWrStart = 3'd1,
      StWrWait  = 3'd2,
      StRdStart = 3'd3,
      StRdWait  = 3'd4,
      StDone    = 3'd5
   } state_e;

   localparam logic [8:0]  SEC_WORDS         = 9'd256;
   localparam logic [31:0] DEF_TEST_SEC_ADDR = 32'd2000;

endpackage

// File: rtl/sd_test_data_gen_if.sv
// Request/data interface between the self-test sequencer and the SD controller.
interface sd_test_data_gen_if;
   logic        sd_init_done;
   logic        wr_start_en;
   logic [31:0] wr_sec_addr;
   logic [15:0] wr_data;
   logic        wr_req;
   logic        wr_busy;
   logic        rd_start_en;
   logic [31:0] rd_sec_addr;
   logic        rd_val_en;
   logic [15:0] rd_val_data;
   logic        rd_busy;

   modport master (
      input  sd_init_done, wr_req, wr_busy, rd_val_en, rd_val_data, rd_busy,
      output wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr
   );

   modport slave (
      output sd_init_done, wr_req, wr_busy, rd_val_en, rd_val_data, rd_busy,
      input  wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr
   );
endinterface

// File: rtl/sig_edge_det.sv
// Single-register edge detector producing combinational rise/fall strobes.
module sig_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;
   assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sd_test_data_gen.sv
// SD-card self-test: writes one sector with an incrementing pattern, reads it back, compares.
module sd_test_data_gen
   import sd_test_pkg::*;
#(
   parameter logic [31:0] TEST_SEC_ADDR = DEF_TEST_SEC_ADDR,
   parameter logic [8:0]  WORDS_PER_SEC = SEC_WORDS,
   parameter logic [15:0] PATTERN_BASE  = 16'd0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sd_test_data_gen_if.master    sd,
   output logic                  error_flag,
   output logic                  test_done
);

   logic init_rise, init_fall, wr_rise, wr_fall, rd_rise, rd_fall;
   logic unused_edges;

   sig_edge_det u_init_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_i (sd.sd_init_done),
      .rise_o(init_rise),
      .fall_o(init_fall)
   );

   sig_edge_det u_wr_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_i (sd.wr_busy),
      .rise_o(wr_rise),
      .fall_o(wr_fall)
   );

   sig_edge_det u_rd_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_i (sd.rd_busy),
      .rise_o(rd_rise),
      .fall_o(rd_fall)
   );

   assign unused_edges = init_fall ^ wr_rise ^ rd_rise;

   state_e      state_q;
   logic [8:0]  wr_cnt_q, rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_data_q, exp_word;
   logic        mismatch_q, mismatch_d;
   logic        wr_start_q, rd_start_q, error_q, done_q;
   logic        wr_adv;

   assign wr_adv   = (state_q == StWrWait) && sd.wr_req && (wr_cnt_q < WORDS_PER_SEC);
   assign exp_word = PATTERN_BASE + 16'(rd_cnt_q);

   // Read check is combinational so a word arriving with the busy fall is folded into the verdict.
   always_comb begin
      rd_cnt_d   = rd_cnt_q;
      mismatch_d = mismatch_q;
      if ((state_q == StRdWait) && sd.rd_val_en) begin
         if (rd_cnt_q < WORDS_PER_SEC) begin
            if (sd.rd_val_data != exp_word) mismatch_d = 1'b1;
            rd_cnt_d = rd_cnt_q + 9'd1;
         end else begin
            mismatch_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         wr_data_q  <= PATTERN_BASE;
         mismatch_q <= 1'b0;
         wr_start_q <= 1'b0;
         rd_start_q <= 1'b0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         wr_start_q <= 1'b0;
         rd_start_q <= 1'b0;
         rd_cnt_q   <= rd_cnt_d;
         mismatch_q <= mismatch_d;
         if (wr_adv) begin
            wr_cnt_q  <= wr_cnt_q + 9'd1;
            wr_data_q <= wr_data_q + 16'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (init_rise) begin
                  state_q    <= StWrStart;
                  wr_start_q <= 1'b1;
               end
            end
            StWrStart: state_q <= StWrWait;
            StWrWait: begin
               if (wr_fall) begin
                  state_q    <= StRdStart;
                  rd_start_q <= 1'b1;
               end
            end
            StRdStart: state_q <= StRdWait;
            StRdWait: begin
               if (rd_fall) begin
                  state_q <= StDone;
                  error_q <= mismatch_d | (rd_cnt_d != WORDS_PER_SEC);
                  done_q  <= 1'b1;
               end
            end
            StDone:  state_q <= StDone;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sd.wr_start_en = wr_start_q;
   assign sd.rd_start_en = rd_start_q;
   assign sd.wr_data     = wr_data_q;
   assign sd.wr_sec_addr = TEST_SEC_ADDR;
   assign sd.rd_sec_addr = TEST_SEC_ADDR;
   assign error_flag     = error_q;
   assign test_done      = done_q;

endmodule

// File: tb/tb_sd_test_data_gen.sv
// Directed bench: two DUTs (pattern base 0 and 16'hFFF0) share one SD-controller model.
module tb_sd_test_data_gen;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        sd_init_done, wr_req, wr_busy, rd_val_en, rd_busy;
   logic [15:0] rd_val_data;
   logic        ef0, td0, ef1, td1;
   logic        sel;

   int errors = 0;
   int checks = 0;

   sd_test_data_gen_if if0 ();
   sd_test_data_gen_if if1 ();

   assign if0.sd_init_done = sd_init_done;
   assign if0.wr_req       = wr_req;
   assign if0.wr_busy      = wr_busy;
   assign if0.rd_val_en    = rd_val_en;
   assign if0.rd_val_data  = rd_val_data;
   assign if0.rd_busy      = rd_busy;
   assign if1.sd_init_done = sd_init_done;
   assign if1.wr_req       = wr_req;
   assign if1.wr_busy      = wr_busy;
   assign if1.rd_val_en    = rd_val_en;
   assign if1.rd_val_data  = rd_val_data;
   assign if1.rd_busy      = rd_busy;

   sd_test_data_gen #(
      .TEST_SEC_ADDR(32'd2000),
      .WORDS_PER_SEC(9'd256),
      .PATTERN_BASE (16'd0)
   ) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sd        (if0),
      .error_flag(ef0),
      .test_done (td0)
   );

   sd_test_data_gen #(
      .TEST_SEC_ADDR(32'd2000),
      .WORDS_PER_SEC(9'd256),
      .PATTERN_BASE (16'hFFF0)
   ) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sd        (if1),
      .error_flag(ef1),
      .test_done (td1)
   );

   logic        o_wr_start, o_rd_start, o_ef, o_td;
   logic [15:0] o_wr_data;
   logic [31:0] o_wr_addr, o_rd_addr;

   always_comb begin
      o_wr_start = sel ? if1.wr_start_en : if0.wr_start_en;
      o_rd_start = sel ? if1.rd_start_en : if0.rd_start_en;
      o_wr_data  = sel ? if1.wr_data     : if0.wr_data;
      o_wr_addr  = sel ? if1.wr_sec_addr : if0.wr_sec_addr;
      o_rd_addr  = sel ? if1.rd_sec_addr : if0.rd_sec_addr;
      o_ef       = sel ? ef1 : ef0;
      o_td       = sel ? td1 : td0;
   end

   function automatic logic [15:0] base_of(input logic s);
      return s ? 16'hFFF0 : 16'h0000;
   endfunction

   task automatic idle_inputs();
      wr_req = 1'b0; wr_busy = 1'b0; rd_val_en = 1'b0; rd_busy = 1'b0; rd_val_data = 16'h0;
   endtask

   // Checks reset values of the selected DUT while rst_n is low.
   task automatic check_reset_vals(input string tag);
      logic [15:0] b;
      b = base_of(sel);
      checks++;
      if ({o_wr_start, o_rd_start, o_ef, o_td} !== 4'b0000) begin
         errors++;
         $display("FAIL %s_ctrl sel=%0d got start/rd/ef/td=%b%b%b%b want 0000",
                  tag, sel, o_wr_start, o_rd_start, o_ef, o_td);
      end
      checks++;
      if (o_wr_data !== b) begin
         errors++;
         $display("FAIL %s_wr_data sel=%0d got %h want %h", tag, sel, o_wr_data, b);
      end
      checks++;
      if (o_wr_addr !== 32'd2000 || o_rd_addr !== 32'd2000) begin
         errors++;
         $display("FAIL %s_addr sel=%0d got wr=%0d rd=%0d want 2000", tag, sel, o_wr_addr,
                  o_rd_addr);
      end
   endtask

   task automatic do_reset();
      logic s;
      s = sel;
      rst_n = 1'b0;
      sd_init_done = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      sel = 1'b0; #1; check_reset_vals("reset");
      sel = 1'b1; #1; check_reset_vals("reset");
      sel = s;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Full controller-side sequence; returns error_flag sampled right after DONE.
   task automatic run_seq(input int n_wr, input int n_rd, input int bad_idx, input int abort_at,
                          input bit drop_init, output logic ef_out);
      logic [15:0] b, exp;
      b = base_of(sel);
      ef_out = 1'bx;
      sd_init_done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_wr_start !== 1'b1) begin
         errors++; $display("FAIL wr_start_pulse got %b want 1", o_wr_start);
      end
      if (drop_init) sd_init_done = 1'b0;
      wr_busy = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_wr_start !== 1'b0) begin
         errors++; $display("FAIL wr_start_once got %b want 0", o_wr_start);
      end
      for (int i = 0; i < n_wr; i++) begin
         exp = b + 16'((i < 256) ? i : 256);
         checks++;
         if (o_wr_data !== exp) begin
            errors++; $display("FAIL wr_data[%0d] got %h want %h", i, o_wr_data, exp);
         end
         wr_req = 1'b1;
         @(posedge clk); #1;
         wr_req = 1'b0;
      end
      exp = b + 16'((n_wr < 256) ? n_wr : 256);
      checks++;
      if (o_wr_data !== exp) begin
         errors++; $display("FAIL wr_data_final got %h want %h", o_wr_data, exp);
      end
      wr_busy = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_rd_start !== 1'b1 || o_td !== 1'b0 || o_ef !== 1'b0) begin
         errors++;
         $display("FAIL rd_start_pulse got rd=%b td=%b ef=%b want 1 0 0", o_rd_start, o_td, o_ef);
      end
      rd_busy = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_rd_start !== 1'b0) begin
         errors++; $display("FAIL rd_start_once got %b want 0", o_rd_start);
      end
      for (int i = 0; i < n_rd; i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals("abort");
            idle_inputs();
            @(posedge clk); #1;
            rst_n = 1'b1;
            ef_out = 1'b0;
            return;
         end
         rd_val_en   = 1'b1;
         rd_val_data = (i == bad_idx) ? 16'h0000 : b + 16'(i);
         if (i == n_rd - 1) rd_busy = 1'b0;  // last word lands with the busy fall
         @(posedge clk); #1;
         if (i == n_rd - 2) begin
            checks++;
            if (o_ef !== 1'b0 || o_td !== 1'b0) begin
               errors++; $display("FAIL pre_done got ef=%b td=%b want 0 0", o_ef, o_td);
            end
         end
      end
      rd_val_en = 1'b0;
      checks++;
      if (o_td !== 1'b1) begin
         errors++; $display("FAIL test_done got %b want 1", o_td);
      end
      ef_out = o_ef;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
   endtask

   task automatic test_clean_pass();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(256, 256, -1, -1, 1'b1, ef);
      checks++;
      if (ef !== 1'b0) begin errors++; $display("FAIL clean_pass ef got %b want 0", ef); end
   endtask

   task automatic test_corrupt_word();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(256, 256, 100, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b1) begin errors++; $display("FAIL corrupt ef got %b want 1", ef); end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (o_ef !== 1'b1 || o_td !== 1'b1) begin
         errors++; $display("FAIL corrupt_sticky got ef=%b td=%b want 1 1", o_ef, o_td);
      end
   endtask

   task automatic test_short_read();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(256, 255, -1, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b1) begin errors++; $display("FAIL short_read ef got %b want 1", ef); end
   endtask

   task automatic test_overrun();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(256, 257, -1, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b1) begin errors++; $display("FAIL overrun ef got %b want 1", ef); end
   endtask

   task automatic test_extra_wr_req();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(260, 256, -1, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b0) begin errors++; $display("FAIL extra_wr ef got %b want 0", ef); end
   endtask

   task automatic test_reset_mid_read();
      logic ef;
      sel = 1'b0;
      do_reset();
      run_seq(256, 256, -1, 50, 1'b0, ef);
      run_seq(256, 256, -1, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b0) begin errors++; $display("FAIL rerun ef got %b want 0", ef); end
   endtask

   task automatic test_pattern_wrap();
      logic ef;
      sel = 1'b1;
      do_reset();
      run_seq(256, 256, -1, -1, 1'b0, ef);
      checks++;
      if (ef !== 1'b0) begin errors++; $display("FAIL wrap ef got %b want 0", ef); end
   endtask

   initial begin
      sel = 1'b0;
      rst_n = 1'b0;
      sd_init_done = 1'b0;
      idle_inputs();
      test_reset();
      test_clean_pass();
      test_corrupt_word();
      test_short_read();
      test_overrun();
      test_extra_wr_req();
      test_reset_mid_read();
      test_pattern_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_test_data_gen.md
Name: sd_test_data_gen

Overview:
- Self-test sequencer for the SD-card path.
- After SD init completes, it writes one sector with an incrementing 16-bit pattern, then reads the sector back and compares every word.
- Drives the SD controller's write/read request interface on one side.
- Produces error_flag for the LED alarm stage on the other side.

Parameters:
- TEST_SEC_ADDR, 32'd2000, sector address used for both the write and the read.
- WORDS_PER_SEC, 9'd256, number of 16-bit words per 512-byte sector.
- PATTERN_BASE, 16'd0, first word of the test pattern.

Ports:
- clk  in  1  system clock, shared with the SD controller.
- rst_n  in  1  reset, asynchronous, active-low.
- sd_init_done  in  1  SD controller initialisation complete (level, clk domain).
- wr_start_en  out  1  one-cycle write-sector request.
- wr_sec_addr  out  32  write sector address.
- wr_data  out  16  current write word.
- wr_req  in  1  controller consumed wr_data; advance to next word.
- wr_busy  in  1  controller write in progress.
- rd_start_en  out  1  one-cycle read-sector request.
- rd_sec_addr  out  32  read sector address.
- rd_val_en  in  1  rd_val_data valid this cycle.
- rd_val_data  in  16  read word from controller.
- rd_busy  in  1  controller read in progress.
- error_flag  out  1  test failed (sticky until reset).
- test_done  out  1  sequence finished (sticky until reset).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state is reset on rst_n low.
- Reset values:
  - wr_start_en=0, rd_start_en=0, wr_data=PATTERN_BASE, error_flag=0, test_done=0.
  - All counters 0, mismatch=0, FSM=IDLE.
  - Edge-detect registers for sd_init_done, wr_busy and rd_busy = 0.
- wr_sec_addr and rd_sec_addr are constant TEST_SEC_ADDR at all times, including reset.
- Edge detection uses one registered copy per signal. rise = sig & ~sig_d; fall = ~sig & sig_d.
  - If sd_init_done is already high at the first cycle after reset, that counts as a rise.
- FSM states: IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, DONE.
  - IDLE: on sd_init_done rise -> WR_START.
  - WR_START: wr_start_en=1 for exactly one cycle -> WR_WAIT.
  - WR_WAIT: on wr_busy fall -> RD_START.
  - RD_START: rd_start_en=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT: on rd_busy fall -> DONE.
  - DONE: terminal until reset; test_done=1.
- Write data:
  - wr_cnt (9 bits) counts wr_req pulses in WR_WAIT.
  - On wr_req with wr_cnt < WORDS_PER_SEC: wr_data <= wr_data+1, taking effect the next cycle; wr_cnt <= wr_cnt+1.
  - wr_data wraps modulo 2^16.
  - wr_req when wr_cnt == WORDS_PER_SEC: ignored; wr_data holds.
  - wr_req outside WR_WAIT: ignored.
- Read check:
  - In RD_WAIT, on rd_val_en with rd_cnt < WORDS_PER_SEC: compare rd_val_data with PATTERN_BASE + rd_cnt (16-bit, modular), then rd_cnt <= rd_cnt+1.
  - On inequality, mismatch <= 1 (sticky).
  - rd_val_en when rd_cnt == WORDS_PER_SEC: sets mismatch (overrun); rd_cnt saturates.
  - rd_val_en outside RD_WAIT: ignored.
- Result:
  - On RD_WAIT -> DONE, error_flag <= mismatch | (rd_cnt != WORDS_PER_SEC). A short read is therefore a failure.
  - error_flag is 0 at all times before DONE.
- Simultaneous events:
  - rd_val_en in the same cycle as rd_busy fall: the word is checked first, and the final rd_cnt includes it.
  - wr_req in the same cycle as wr_busy fall: the counter still advances; no effect on the result.
- sd_init_done deassert mid-test: ignored. Only rst_n restarts the sequence.
- Reset mid-operation: immediate return to the reset values. The test reruns on the next sd_init_done rise, including a level that is high right after reset.
- No handshake timeout. A controller that never drops busy leaves the FSM waiting, with error_flag=0.

Decomposition:
- Shared package sd_test_pkg:
  - FSM state enum, 3-bit encoding.
  - SEC_WORDS constant (256).
  - Default TEST_SEC_ADDR.
- One sub-module, sig_edge_det (1-bit register, rise/fall outputs). Instantiated three times: sd_init_done, wr_busy, rd_busy.

Test Plan:
1. Clean pass: raise sd_init_done; controller model issues 256 wr_req, then returns the same 256 words 0..255 -> one wr_start_en pulse, one rd_start_en pulse, wr_data sequence 0..255, test_done=1, error_flag=0.
2. Single corrupt word: model returns word 100 as 16'h0000 instead of 16'h0064 -> error_flag=1 at DONE and stays 1.
3. Short read: model returns only 255 words then drops rd_busy -> error_flag=1. Overrun variant: 257 words -> error_flag=1.
4. Extra wr_req: 260 wr_req pulses -> wr_data stops at 16'h0100 (PATTERN_BASE=0). Readback of 0..255 still passes.
5. Reset mid-read: pulse rst_n low at word 50 of the read -> all outputs return to reset values. Test reruns from IDLE, and a clean second pass gives error_flag=0.
6. PATTERN_BASE=16'hFFF0: check wrap 16'hFFFF -> 16'h0000 in both write and compare paths; pass expected.
